// File: rtl/fb_scoreboard.sv
// fb_scoreboard
//   Register busy scoreboard for a pipeline with long-latency loads. A busy
//   bit is kept per architectural register. It is set when a load issues
//   from ID and cleared when that load writes back. The block stalls ID on
//   three conditions: a RAW hazard on a busy source, a WAW hazard on a busy
//   destination, or a load issuing while all load slots are in use.
//
// Parameters
//   MAX_OUTSTANDING  maximum number of loads in flight (1..7)
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_*                instruction presented in ID (sources, dest, load, flush)
//   wb_valid/_rd        load write-back this cycle
//   stall               hold PC and IF/ID, bubble into ID/EX (combinational)
//   busy_vec            per-register busy bits (bit 0 is always 0)
//   outstanding         popcount of busy_vec
//   wb_err              sticky: a write-back hit a non-busy register
//   stall_cycles        saturating count of stalled cycles
module fb_scoreboard #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_register_rs1,
    input  logic [4:0]  id_register_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_register_rd,
    input  logic        id_is_load,
    input  logic        id_flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_register_rd,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic [2:0]  outstanding,
    output logic        wb_err,
    output logic [15:0] stall_cycles
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic        wb_hit;
    logic        wb_miss;
    logic [31:0] wb_clr;
    logic [31:0] busy_after;
    logic [2:0]  out_after;
    logic        raw;
    logic        waw;
    logic        full;
    logic        issue;
    logic [31:0] issue_set;
    logic [31:0] busy_next;

    always_comb begin
        // x0 is never tracked, so a write-back to it neither clears nor errors.
        wb_hit  = wb_valid && (wb_register_rd != 5'd0) &&  busy_vec[wb_register_rd];
        wb_miss = wb_valid && (wb_register_rd != 5'd0) && !busy_vec[wb_register_rd];
        wb_clr  = wb_hit ? (32'd1 << wb_register_rd) : 32'd0;

        // Hazards are evaluated against the state after this cycle's
        // write-back. The register file and forwarding path supply the
        // returning data, so a same-cycle write-back never stalls.
        busy_after = busy_vec & ~wb_clr;
        out_after  = outstanding - {2'b00, wb_hit};

        raw  = (id_use_rs1 && busy_after[id_register_rs1]) ||
               (id_use_rs2 && busy_after[id_register_rs2]);
        waw  = id_is_load && busy_after[id_register_rd];
        full = id_is_load && (out_after == MAX_CNT);

        stall = id_valid && !id_flush && (raw || waw || full);
        issue = id_valid && !id_flush && !stall && id_is_load &&
                (id_register_rd != 5'd0);

        // Clear first, then set. A write-back and an issue to the same rd
        // therefore leave the bit set and the count unchanged.
        issue_set = issue ? (32'd1 << id_register_rd) : 32'd0;
        busy_next = (busy_after | issue_set) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec     <= '0;
            outstanding  <= '0;
            wb_err       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            busy_vec    <= busy_next;
            // The full check blocks any issue that would push the count
            // past MAX_OUTSTANDING, so this sum cannot wrap.
            outstanding <= out_after + {2'b00, issue};
            wb_err      <= wb_err | wb_miss;
            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
